// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer/empty controller for the async port FIFO, with a 2-entry FWFT output buffer.
// Optional almost_empty output and AE_THRESH parameter enabled by defining FIFO_RD_ALMOST_EMPTY_EN.
module fifo_rd_ctrl #(
  parameter int PTR_SZ = 2,
  parameter int DATA_W = 8
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  , parameter int AE_THRESH = 1
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PTR_SZ:0]   rq2_waddr,
  output logic [PTR_SZ:0]   raddr_gray,
  output logic [PTR_SZ-1:0] raddr,
  output logic              ren,
  input  logic [DATA_W-1:0] rdata_mem,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              empty,
  output logic [PTR_SZ:0]   rd_count
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  , output logic            almost_empty
`endif
);

  logic [PTR_SZ:0]   rbin_q, rbin_d;
  logic [PTR_SZ:0]   rgray_q, rgray_d;
  logic [PTR_SZ:0]   wbin;
  logic [PTR_SZ:0]   rd_count_q, rd_count_d;
  logic              empty_q, empty_d;
  logic              inflight_q;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];
  logic              pop;
  logic              capture;
  logic [2:0]        pend;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
  for (genvar gi = 0; gi <= PTR_SZ; gi++) begin : g_wbin
    assign wbin[gi] = ^rq2_waddr[PTR_SZ:gi];
  end

  assign pop     = (occ_q != 2'd0) & dout_ready;
  assign capture = inflight_q;

  // Words already held or returning, after this cycle's pop; issue only if one slot stays free
  assign pend = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign ren  = !rst && !empty_q && (pend < 3'd2);

  always_comb begin
    rbin_d     = rbin_q + {{PTR_SZ{1'b0}}, ren};
    rgray_d    = (rbin_d >> 1) ^ rbin_d;
    empty_d    = (rgray_d == rq2_waddr);
    rd_count_d = wbin - rbin_d;
    occ_d      = occ_q + {1'b0, capture} - {1'b0, pop};
  end

  // Slot 0 is always the head; a returning word lands in the first free slot after any pop
  always_comb begin
    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    if (pop) begin
      buf_d[0] = buf_q[1];
    end
    if (capture) begin
      if (occ_q == {1'b0, pop}) begin
        buf_d[0] = rdata_mem;
      end else begin
        buf_d[1] = rdata_mem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rbin_q     <= '0;
      rgray_q    <= '0;
      empty_q    <= 1'b1;
      rd_count_q <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      rbin_q     <= rbin_d;
      rgray_q    <= rgray_d;
      empty_q    <= empty_d;
      rd_count_q <= rd_count_d;
      inflight_q <= ren;
      occ_q      <= occ_d;
      for (int i = 0; i < 2; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  localparam logic [PTR_SZ:0] AE_THRESH_V = AE_THRESH[PTR_SZ:0];
  logic almost_empty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_empty_q <= 1'b1;
    end else begin
      almost_empty_q <= (rd_count_d <= AE_THRESH_V);
    end
  end

  assign almost_empty = almost_empty_q;
`endif

  assign raddr_gray = rgray_q;
  assign raddr      = rbin_q[PTR_SZ-1:0];
  assign dout       = buf_q[0];
  assign dout_valid = (occ_q != 2'd0);
  assign empty      = empty_q;
  assign rd_count   = rd_count_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: bench-side memory model and write pointer, hand-computed expectations.
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rq2_waddr = 3'b000;
  logic [2:0] raddr_gray;
  logic [1:0] raddr;
  logic       ren;
  logic [7:0] rdata_mem = 8'h00;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       empty;
  logic [2:0] rd_count;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic       almost_empty;
`endif

  int checks = 0;
  int failures = 0;
  int nren;
  logic [7:0] mem [4];
  logic [2:0] wptr = 3'b000;
  logic [2:0] gtab [10] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                            3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
  logic [7:0] exp_words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  fifo_rd_ctrl #(.PTR_SZ(2), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rq2_waddr  (rq2_waddr),
    .raddr_gray (raddr_gray),
    .raddr      (raddr),
    .ren        (ren),
    .rdata_mem  (rdata_mem),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .empty      (empty),
    .rd_count   (rd_count)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    , .almost_empty (almost_empty)
`endif
  );

  always #5 clk = ~clk;

  // Memory with registered read: data appears the cycle after ren
  always @(posedge clk) begin
    if (ren) rdata_mem <= mem[raddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wptr[1:0]] = d;
    wptr = wptr + 3'd1;
    rq2_waddr = wptr ^ (wptr >> 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rq2_waddr = 3'b101;
    tick();
    tick();
    rst = 1'b0;
    rq2_waddr = 3'b000;
    wptr = 3'b000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with arbitrary inputs
    rst = 1'b1;
    rq2_waddr = 3'b101;
    dout_ready = 1'b1;
    rdata_mem = 8'h5a;
    tick();
    tick();
    check("rst_gray", raddr_gray, 3'b000);
    check("rst_empty", empty, 1'b1);
    check("rst_ren", ren, 1'b0);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_count", rd_count, 3'd0);
    check("rst_dout", dout, 8'h00);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    check("rst_ae", almost_empty, 1'b1);
`endif
    rst = 1'b0;
    rq2_waddr = 3'b000;
    wptr = 3'b000;

    // Single word latency
    tick();
    push(8'ha5);
    tick();
    check("sw_ren_n1", ren, 1'b1);
    check("sw_raddr_n1", raddr, 2'd0);
    check("sw_empty_n1", empty, 1'b0);
    check("sw_valid_n1", dout_valid, 1'b0);
    tick();
    check("sw_empty_n2", empty, 1'b1);
    check("sw_gray_n2", raddr_gray, 3'b001);
    check("sw_ren_n2", ren, 1'b0);
    tick();
    check("sw_valid_n3", dout_valid, 1'b1);
    check("sw_dout_n3", dout, 8'ha5);
    check("sw_gray_n3", raddr_gray, 3'b001);
    tick();
    check("sw_valid_n4", dout_valid, 1'b0);

    // Back-pressure: 4 words, downstream stalled
    do_reset();
    dout_ready = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) push(exp_words[k]);
    nren = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) check("bp_count_full", rd_count, 3'd4);
      if (ren) nren++;
    end
    check("bp_ren_pulses", nren, 2);
    check("bp_valid", dout_valid, 1'b1);
    check("bp_head", dout, 8'h11);
    dout_ready = 1'b1;
    #1;
    check("bp_ren_resume", ren, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("bp_drain_valid", dout_valid, 1'b1);
      check("bp_drain_data", dout, exp_words[k]);
      tick();
    end
    check("bp_done_valid", dout_valid, 1'b0);
    check("bp_done_empty", empty, 1'b1);
    check("bp_done_count", rd_count, 3'd0);

    // Wrap-around: 9 single-word transactions
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("wr_gray_pre", raddr_gray, gtab[i]);
      push(8'h30 + 8'(i));
      tick();
      check("wr_ren", ren, 1'b1);
      check("wr_raddr", raddr, 32'(i % 4));
      tick();
      check("wr_gray_post", raddr_gray, gtab[i+1]);
      tick();
      check("wr_valid", dout_valid, 1'b1);
      check("wr_data", dout, 8'h30 + 8'(i));
      tick();
    end

    // Count: rbin=010 against wbin=100, then 101
    do_reset();
    dout_ready = 1'b0;
    tick();
    push(8'ha1); push(8'ha2); push(8'ha3); push(8'ha4);
    repeat (6) tick();
    check("cnt_gray", raddr_gray, 3'b011);
    check("cnt_two", rd_count, 3'd2);
    check("cnt_empty", empty, 1'b0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    check("cnt_ae", almost_empty, 1'b0);
`endif
    push(8'ha5);
    check("cnt_waddr", rq2_waddr, 3'b111);
    tick();
    check("cnt_three", rd_count, 3'd3);

    // Reset mid-stream with words buffered and one read in flight
    dout_ready = 1'b1;
    #1;
    check("mr_ren", ren, 1'b1);
    tick();
    check("mr_valid_pre", dout_valid, 1'b1);
    check("mr_head_pre", dout, 8'ha2);
    rst = 1'b1;
    rq2_waddr = 3'b000;
    wptr = 3'b000;
    dout_ready = 1'b0;
    tick();
    check("mr_valid", dout_valid, 1'b0);
    check("mr_empty", empty, 1'b1);
    check("mr_gray", raddr_gray, 3'b000);
    check("mr_count", rd_count, 3'd0);
    check("mr_ren_rst", ren, 1'b0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    check("mr_ae", almost_empty, 1'b1);
`endif
    rst = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_stale_valid", dout_valid, 1'b0);
      check("mr_stale_ren", ren, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
